game_status_scanner: RTL and testbench
======================================

Name: game_status_scanner

Overview:
Sequential, parametrised successor to the combinational win checker. On a start request it snapshots an N x N board of tile values and scans one cell per cycle. It reports win (any tile >= 2**WIN_EXP), lose (no empty cell and no adjacent equal pair) and the count of empty cells. It sits between the move/merge engine and the game-control FSM, which issues start after each spawned tile.

Parameters:
BOARD_N, 4, board side length; N*N cells; must be >= 2
TILE_W, 12, width of one tile value (plain binary value, e.g. 2048 = 12'h800)
WIN_EXP, 11, win threshold exponent; win when tile >= 2**WIN_EXP; must be < TILE_W

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  scan request; sampled only when busy = 0
board_in  input  TILE_W x BOARD_N x BOARD_N  unpacked board, board_in[row][col]
busy  output  1  scan in progress
done  output  1  one-cycle pulse; results valid from this cycle
win  output  1  win result, held until next accepted start
lose  output  1  lose result, held until next accepted start
empty_count  output  $clog2(BOARD_N*BOARD_N+1)  number of zero tiles

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; busy, done, win, lose = 0; empty_count = 0; index = 0.
  - Reset mid-scan aborts the scan; no done pulse is produced.
- FSM states are IDLE and SCAN.
- IDLE:
  - start = 1 at a rising edge is accepted.
  - On acceptance: snapshot board_in into an internal register; clear win, lose, empty_count and the accumulators; index = 0; go to SCAN; busy = 1 from that edge.
- SCAN: each cycle evaluates the snapshot cell at index; row = index / N, col = index % N.
  - win_acc |= (tile >= 2**WIN_EXP), unsigned compare.
  - empty_acc += (tile == 0).
  - move_acc |= (tile == 0), OR (col < N-1 and tile == right neighbour and tile != 0), OR (row < N-1 and tile == down neighbour and tile != 0).
  - Last row/column do not wrap to a neighbour.
- Completion: on the edge that evaluates index N*N-1:
  - go to IDLE with busy = 0 and done = 1 for exactly one cycle.
  - win = win_acc; lose = !win_acc && !move_acc; empty_count = empty_acc (all include the final cell).
- Latency: done is high N*N cycles after the start-sampling edge (16 for N = 4).
- win and lose are never both 1.
- Snapshot isolation: board_in changes during SCAN have no effect on results.
- start while busy = 1 is ignored; it is not queued.
- start asserted in the done cycle is accepted, since state is IDLE; back-to-back scans therefore cost N*N + 1 cycles each.
- An index counter wrap beyond N*N-1 is unreachable; it must not re-enter SCAN without a new start.

Optional Feature:
Macro GAME_STATUS_EARLY_EXIT_EN.
- Defined: when the cell at index k sets win_acc, the scan terminates on that edge.
  - done pulses k+1 cycles after start; win = 1, lose = 0.
  - empty_count covers cells 0..k only.
- Undefined: every scan runs all N*N cells regardless of win.

Decomposition:
- Package game2048_pkg:
  - BOARD_N_DEF, TILE_W_DEF and WIN_EXP_DEF constants.
  - tile_t typedef (logic [TILE_W-1:0]).
  - scan_state_e enum {IDLE, SCAN}.
- One natural sub-module, game_cell_eval (combinational).
  - Inputs: tile, right neighbour, down neighbour, edge flags.
  - Outputs: is_win, is_empty, has_move.
  - game_status_scanner instantiates it once and muxes the cell by index.

Test Plan:
(N = 4, TILE_W = 12, WIN_EXP = 11)
1. All tiles 0, pulse start -> done exactly 16 cycles later, one cycle wide; win = 0, lose = 0, empty_count = 16; busy high for 16 cycles.
2. All 0 except [1][1] = 12'h800 -> win = 1, lose = 0, empty_count = 15. With GAME_STATUS_EARLY_EXIT_EN defined: done at cycle 6, empty_count = 5.
3. Full board alternating 2/4 checkerboard (no zeros, no equal neighbours) -> win = 0, lose = 1, empty_count = 0. Variant: set [3][2] = [3][3] = 8 -> lose = 0 (bottom-row horizontal merge). Variant: set [2][3] = [3][3] = 8 -> lose = 0 (last-column vertical merge).
4. Board with [2][1] = 12'h040 (64), rest 0 -> win = 0. [0][0] = 12'h1000 is illegal for TILE_W = 12; instead set TILE_W = 13 and tile = 4096 -> win = 1 (>= compare).
5. Start scan of the checkerboard, at cycle 3 change board_in to all zeros and pulse start again -> second start ignored; done at cycle 16 with lose = 1. Then assert start in the done cycle -> new scan accepted, done 17 cycles after the first done.
6. Assert rst_n = 0 at cycle 5 of a scan -> busy, win, lose, empty_count = 0 immediately; no done pulse. After release, a new start completes normally.

Source files
------------

// File: rtl/game2048_pkg.sv
// Shared constants and types for the 2048 board status logic.
package game2048_pkg;

  localparam int BOARD_N_DEF = 4;
  localparam int TILE_W_DEF  = 12;
  localparam int WIN_EXP_DEF = 11;

  typedef logic [TILE_W_DEF-1:0] tile_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/game_cell_eval.sv
// Combinational evaluation of one board cell against its right and down neighbours.
module game_cell_eval
  import game2048_pkg::*;
#(
  parameter int TILE_W  = TILE_W_DEF,
  parameter int WIN_EXP = WIN_EXP_DEF
) (
  input  logic [TILE_W-1:0] tile,
  input  logic [TILE_W-1:0] right,
  input  logic [TILE_W-1:0] down,
  input  logic              has_right,
  input  logic              has_down,
  output logic              is_win,
  output logic              is_empty,
  output logic              has_move
);

  localparam logic [TILE_W-1:0] WIN_TH = TILE_W'(1) << WIN_EXP;

  logic merge_right;
  logic merge_down;

  assign is_win      = (tile >= WIN_TH);
  assign is_empty    = (tile == '0);
  // Two empty neighbours are not a merge; an empty cell already counts as a move.
  assign merge_right = has_right && !is_empty && (tile == right);
  assign merge_down  = has_down  && !is_empty && (tile == down);
  assign has_move    = is_empty || merge_right || merge_down;

endmodule

// File: rtl/game_status_scanner.sv
// Sequential win/lose/empty-count scanner, one cell per cycle over a board snapshot.
// Optional macro GAME_STATUS_EARLY_EXIT_EN ends the scan at the first winning cell.
module game_status_scanner
  import game2048_pkg::*;
#(
  parameter int BOARD_N = BOARD_N_DEF,
  parameter int TILE_W  = TILE_W_DEF,
  parameter int WIN_EXP = WIN_EXP_DEF,
  localparam int CELLS  = BOARD_N * BOARD_N,
  localparam int CNT_W  = $clog2(CELLS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] board_in [BOARD_N][BOARD_N],
  output logic              busy,
  output logic              done,
  output logic              win,
  output logic              lose,
  output logic [CNT_W-1:0]  empty_count
);

  localparam int IDX_W = $clog2(CELLS);
  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(BOARD_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  // Handshake: start is taken on any rising edge where busy = 0; results are
  // valid from the done pulse and held until the next accepted start.

  scan_state_e       state;
  logic [IDX_W-1:0]  index;
  logic              win_acc;
  logic              move_acc;
  logic [CNT_W-1:0]  empty_acc;
  logic [TILE_W-1:0] snap [CELLS];

  logic [IDX_W-1:0]  row;
  logic [IDX_W-1:0]  col;
  logic              has_right;
  logic              has_down;
  logic [IDX_W-1:0]  right_idx;
  logic [IDX_W-1:0]  down_idx;
  logic              cell_win;
  logic              cell_empty;
  logic              cell_move;
  logic              win_nxt;
  logic              move_nxt;
  logic [CNT_W-1:0]  empty_nxt;
  logic              last_cell;
  logic              accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < BOARD_N; r++) begin
        for (int c = 0; c < BOARD_N; c++) begin
          snap[r*BOARD_N + c] <= board_in[r][c];
        end
      end
    end
  end

  assign row       = index / N_IDX;
  assign col       = index % N_IDX;
  assign has_right = (col != N_IDX - IDX_W'(1));
  assign has_down  = (row != N_IDX - IDX_W'(1));
  // Edge cells point the neighbour mux back at themselves; the flags mask them out.
  assign right_idx = has_right ? index + IDX_W'(1) : index;
  assign down_idx  = has_down  ? index + N_IDX     : index;

  game_cell_eval #(
    .TILE_W  (TILE_W),
    .WIN_EXP (WIN_EXP)
  ) u_cell (
    .tile      (snap[index]),
    .right     (snap[right_idx]),
    .down      (snap[down_idx]),
    .has_right (has_right),
    .has_down  (has_down),
    .is_win    (cell_win),
    .is_empty  (cell_empty),
    .has_move  (cell_move)
  );

  assign win_nxt   = win_acc  | cell_win;
  assign move_nxt  = move_acc | cell_move;
  assign empty_nxt = empty_acc + CNT_W'(cell_empty);

`ifdef GAME_STATUS_EARLY_EXIT_EN
  assign last_cell = (index == LAST_IDX) || cell_win;
`else
  assign last_cell = (index == LAST_IDX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      index       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      empty_count <= '0;
      win_acc     <= 1'b0;
      move_acc    <= 1'b0;
      empty_acc   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SCAN;
            busy        <= 1'b1;
            index       <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
            empty_count <= '0;
            win_acc     <= 1'b0;
            move_acc    <= 1'b0;
            empty_acc   <= '0;
          end
        end
        SCAN: begin
          win_acc   <= win_nxt;
          move_acc  <= move_nxt;
          empty_acc <= empty_nxt;
          if (last_cell) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            index       <= '0;
            win         <= win_nxt;
            lose        <= !win_nxt && !move_nxt;
            empty_count <= empty_nxt;
          end else begin
            index <= index + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_status_scanner.sv
// Randomised and directed bench for game_status_scanner with a queued scoreboard.
module tb_game_status_scanner;

  localparam int N     = 4;
  localparam int TW    = 12;
  localparam int WE    = 11;
  localparam int CELLS = N * N;
  localparam int CW    = $clog2(CELLS + 1);
  localparam int EW    = 32 + 2 + CW;

  typedef logic [TW-1:0] board_t [N][N];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  board_t        board_in;
  logic          busy;
  logic          done;
  logic          win;
  logic          lose;
  logic [CW-1:0] empty_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic prev_done = 1'b0;
  logic [EW-1:0] exp_q[$];

  game_status_scanner #(
    .BOARD_N (N),
    .TILE_W  (TW),
    .WIN_EXP (WE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .board_in    (board_in),
    .busy        (busy),
    .done        (done),
    .win         (win),
    .lose        (lose),
    .empty_count (empty_count)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: game rules applied to the whole board at once.
  function automatic logic [EW-1:0] model(input board_t b, input int sample_cyc);
    int   empties = 0;
    int   lat     = CELLS;
    int   first_win = -1;
    logic w  = 1'b0;
    logic mv = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (b[r][c] == 0) begin empties++; mv = 1'b1; end
        if (b[r][c] >= (1 << WE)) begin
          w = 1'b1;
          if (first_win < 0) first_win = r * N + c;
        end
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c + 1 < N; c++)
        if (b[r][c] != 0 && b[r][c] == b[r][c+1]) mv = 1'b1;
    for (int r = 0; r + 1 < N; r++)
      for (int c = 0; c < N; c++)
        if (b[r][c] != 0 && b[r][c] == b[r+1][c]) mv = 1'b1;
`ifdef GAME_STATUS_EARLY_EXIT_EN
    if (first_win >= 0) begin
      lat = first_win + 1;
      empties = 0;
      for (int k = 0; k <= first_win; k++)
        if (b[k / N][k % N] == 0) empties++;
    end
`endif
    return {32'(sample_cyc + lat), w, (!w && !mv), CW'(empties)};
  endfunction

  // monitor: pops an expectation on each done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done) check("done_width", {63'd0, done}, 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
          check("win", {63'd0, win}, {63'd0, e[CW+1]});
          check("lose", {63'd0, lose}, {63'd0, e[CW]});
          check("empty_count", 64'(empty_count), 64'(e[CW-1:0]));
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // driver: called before a rising edge, so that edge samples start
  task automatic start_scan(input board_t b);
    board_in = b;
    start = 1'b1;
    exp_q.push_back(model(b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_drain();
    logic drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy) begin drained = 1'b1; break; end
    end
    check("drain", {63'd0, drained}, 64'd1);
  endtask

  task automatic wait_done();
    logic seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", {63'd0, seen}, 64'd1);
  endtask

  function automatic board_t fill(input logic [TW-1:0] v);
    board_t b;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) b[r][c] = v;
    return b;
  endfunction

  function automatic board_t checker_board();
    board_t b;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) b[r][c] = ((r + c) % 2 == 0) ? TW'(2) : TW'(4);
    return b;
  endfunction

  function automatic board_t rand_board();
    board_t b;
    int zero_pct = $urandom_range(0, 40);
    int max_e    = $urandom_range(2, 11);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 99) < zero_pct) b[r][c] = '0;
        else b[r][c] = TW'(1) << $urandom_range(1, max_e);
    return b;
  endfunction

  initial begin
    board_t b;
    board_in = fill('0);
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_win", {63'd0, win}, 64'd0);
    check("rst_lose", {63'd0, lose}, 64'd0);
    check("rst_empty", 64'(empty_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // empty board
    start_scan(fill('0)); wait_drain();
    // single winning tile in the middle
    b = fill('0); b[1][1] = 12'h800;
    start_scan(b); wait_drain();
    // just below the threshold, and the largest value
    b = fill('0); b[2][1] = 12'h040; b[0][3] = 12'h7FF;
    start_scan(b); wait_drain();
    b = checker_board(); b[3][0] = 12'hFFF;
    start_scan(b); wait_drain();
    // locked board, then bottom-row and last-column merges
    start_scan(checker_board()); wait_drain();
    b = checker_board(); b[3][2] = 12'd8; b[3][3] = 12'd8;
    start_scan(b); wait_drain();
    b = checker_board(); b[2][3] = 12'd8; b[3][3] = 12'd8;
    start_scan(b); wait_drain();
    // no wrap from last column to next row's first cell
    b = checker_board(); b[0][3] = 12'd32; b[1][0] = 12'd32;
    start_scan(b); wait_drain();

    // start while busy is ignored; board changes do not leak into the snapshot
    start_scan(checker_board());
    repeat (2) @(negedge clk);
    board_in = fill('0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // start in the done cycle is accepted
    start_scan(fill('0)); wait_drain();

    // reset mid-scan aborts without a done pulse
    b = fill('0); b[3][3] = 12'h800;
    start_scan(b);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_win", {63'd0, win}, 64'd0);
    check("abort_lose", {63'd0, lose}, 64'd0);
    check("abort_empty", 64'(empty_count), 64'd0);
    exp_q.delete();
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_scan(b); wait_drain();

    // randomised boards, some issued back-to-back in the done cycle
    for (int i = 0; i < 40; i++) begin
      start_scan(rand_board());
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
        start_scan(rand_board());
      end
      wait_drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
